max_pooling_stream: RTL

Parametrised streaming max-pooling stage, the multi-bit, N-channel generalisation of the 16-channel 1-bit pooling layer. It consumes a raster-ordered feature map, one pixel per channel per `valid_in` beat, from the upstream convolution stage. It emits the 2x2, stride-2 max-pooled map to the next layer. Feature-map geometry, channel count, sample width and signedness are parameters, and the input stream may contain arbitrary gaps.

---
 rtl/max_pooling_stream.sv | 97 +++++++++
 1 files changed

// File: rtl/max_pooling_stream.sv
// Streaming 2x2 / stride-2 max pooling over a raster-ordered, N-channel feature map.
// One pixel is taken per valid_in beat; the pooled pixel follows the window's bottom-right beat by one cycle.
module max_pooling_stream #(
  parameter int CHANNELS   = 16,
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 11,
  parameter int HEIGHT     = 11,
  parameter int SIGNED     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0] pixel_in,
  output logic                           valid_out,
  output logic [CHANNELS*DATA_WIDTH-1:0] pixel_out,
  output logic                           frame_done
);

  localparam int PW = CHANNELS * DATA_WIDTH;
  localparam int OW = WIDTH / 2;
  localparam int OH = HEIGHT / 2;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int LW = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_POOL_LAST = CW'(2 * OW - 1);
  localparam logic [RW-1:0] ROW_POOL_LAST = RW'(2 * OH - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] hold;
  logic [PW-1:0] linebuf [OW];
  logic [PW-1:0] line_rd;
  logic [PW-1:0] pair_max;
  logic [PW-1:0] pool_max;
  logic [LW-1:0] lb_idx;
  logic          in_region;

  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic a_wins;
    if (SIGNED != 0) a_wins = $signed(a) > $signed(b);
    else             a_wins = a > b;
    return a_wins ? a : b;
  endfunction

  always_comb begin
    lb_idx    = LW'(col >> 1);
    in_region = (col <= COL_POOL_LAST) && (row <= ROW_POOL_LAST);
    line_rd   = linebuf[lb_idx];
    pair_max  = '0;
    pool_max  = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      pair_max[c*DATA_WIDTH +: DATA_WIDTH] = max2(hold[c*DATA_WIDTH +: DATA_WIDTH],
                                                  pixel_in[c*DATA_WIDTH +: DATA_WIDTH]);
      pool_max[c*DATA_WIDTH +: DATA_WIDTH] = max2(line_rd[c*DATA_WIDTH +: DATA_WIDTH],
                                                  pair_max[c*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      pixel_out  <= '0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (in_region && col[0] && row[0]) begin
          pixel_out  <= pool_max;
          valid_out  <= 1'b1;
          frame_done <= (col == COL_POOL_LAST) && (row == ROW_POOL_LAST);
        end
      end
    end
  end

  // Hold register and line buffer carry no reset: each entry is rewritten before use in every frame.
  always_ff @(posedge clk) begin
    if (!rst && valid_in && in_region) begin
      if (!col[0])      hold            <= pixel_in;
      else if (!row[0]) linebuf[lb_idx] <= pair_max;
    end
  end

endmodule
